uart_rx_frame_checker: RTL



---
 rtl/uart_rx_frame_checker_if.sv | 69 ++++++
 rtl/uart_rx_frame_checker.sv | 114 +++++++++++
 2 files changed

// File: rtl/uart_rx_frame_checker_if.sv
// Bundle between the UART RX control FSM and its frame-checker datapath.
// err_cnt exists only when UART_RX_ERR_CNT_EN is defined.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  RX_IN;
  logic [5:0]            Prescale;
  logic [5:0]            edge_cnt;
  logic                  dat_samp_en;
  logic                  strt_chk_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  stp_chk_en;
  logic                  PAR_TYP;
  logic                  data_valid;
  logic                  sampled_bit;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  RX_VLD;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]            err_cnt;
`endif

  modport master (
`ifdef UART_RX_ERR_CNT_EN
    input  err_cnt,
`endif
    output RX_IN,
    output Prescale,
    output edge_cnt,
    output dat_samp_en,
    output strt_chk_en,
    output deser_en,
    output par_chk_en,
    output stp_chk_en,
    output PAR_TYP,
    output data_valid,
    input  sampled_bit,
    input  strt_glitch,
    input  par_err,
    input  stp_err,
    input  P_DATA,
    input  RX_VLD
  );

  modport slave (
`ifdef UART_RX_ERR_CNT_EN
    output err_cnt,
`endif
    input  RX_IN,
    input  Prescale,
    input  edge_cnt,
    input  dat_samp_en,
    input  strt_chk_en,
    input  deser_en,
    input  par_chk_en,
    input  stp_chk_en,
    input  PAR_TYP,
    input  data_valid,
    output sampled_bit,
    output strt_glitch,
    output par_err,
    output stp_err,
    output P_DATA,
    output RX_VLD
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX datapath: majority-vote sampler, deserializer, start/parity/stop checks.
// Optional saturating error counter under UART_RX_ERR_CNT_EN.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8
) (
  input logic                     CLK,
  input logic                     RST,
  uart_rx_frame_checker_if.slave  bus
);

  logic [5:0] h;
  logic [5:0] hm1;
  logic [5:0] hp1;
  logic [5:0] hp2;
  logic       strobe;
  logic       maj;
  logic       exp_par;

  logic                  s0_q;
  logic                  s1_q;
  logic                  smp_q;
  logic                  gl_q;
  logic                  perr_q;
  logic                  serr_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] pdata_q;

  assign h   = bus.Prescale >> 1;
  assign hm1 = h - 6'd1;
  assign hp1 = h + 6'd1;
  assign hp2 = h + 6'd2;

  assign strobe  = bus.dat_samp_en && (bus.edge_cnt == hp2);
  assign maj     = (s0_q & s1_q) | (s0_q & bus.RX_IN)
                 | (s1_q & bus.RX_IN);
  assign exp_par = bus.PAR_TYP ? ~^shreg_q : ^shreg_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q  <= 1'b1;
      s1_q  <= 1'b1;
      smp_q <= 1'b1;
    end else if (bus.dat_samp_en) begin
      if (bus.edge_cnt == hm1) s0_q  <= bus.RX_IN;
      if (bus.edge_cnt == h)   s1_q  <= bus.RX_IN;
      if (bus.edge_cnt == hp1) smp_q <= maj;
    end
  end

  // Only one enable is expected per strobe; the chain is a fallback order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gl_q    <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      shreg_q <= '0;
    end else begin
      gl_q <= 1'b0;
      if (strobe) begin
        if (bus.strt_chk_en) begin
          gl_q    <= smp_q;
          perr_q  <= 1'b0;
          serr_q  <= 1'b0;
          shreg_q <= '0;
        end else if (bus.deser_en) begin
          shreg_q <= {smp_q, shreg_q[DATA_WIDTH-1:1]};
        end else if (bus.par_chk_en) begin
          perr_q <= (smp_q != exp_par);
        end else if (bus.stp_chk_en) begin
          serr_q <= ~smp_q;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q   <= 1'b0;
      pdata_q <= '0;
    end else begin
      vld_q <= bus.data_valid;
      if (bus.data_valid) pdata_q <= shreg_q;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] ecnt_q;
  logic [7:0] ecnt_d;
  logic       inc;

  assign inc = (bus.data_valid && (perr_q | serr_q)) || gl_q;

  always_comb begin
    ecnt_d = ecnt_q;
    if (inc && (ecnt_q != 8'hFF)) ecnt_d = ecnt_q + 8'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ecnt_q <= 8'd0;
    else      ecnt_q <= ecnt_d;
  end

  assign bus.err_cnt = ecnt_q;
`endif

  assign bus.sampled_bit = smp_q;
  assign bus.strt_glitch = gl_q;
  assign bus.par_err     = perr_q;
  assign bus.stp_err     = serr_q;
  assign bus.P_DATA      = pdata_q;
  assign bus.RX_VLD      = vld_q;

endmodule
